// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants for the seven-segment scan driver
package seg7_pkg;

  typedef logic [6:0] seg_t;

  // Segment bit positions within seg_t ({g,f,e,d,c,b,a})
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  // All segments off (active-low)
  localparam seg_t SEG_BLANK = 7'h7F;

  // Active-low digit patterns
  localparam seg_t SEG_0 = 7'b1000000;
  localparam seg_t SEG_1 = 7'b1111001;
  localparam seg_t SEG_2 = 7'b0100100;
  localparam seg_t SEG_3 = 7'b0110000;
  localparam seg_t SEG_4 = 7'b0011001;
  localparam seg_t SEG_5 = 7'b0010010;
  localparam seg_t SEG_6 = 7'b0000010;
  localparam seg_t SEG_7 = 7'b1111000;
  localparam seg_t SEG_8 = 7'b0000000;
  localparam seg_t SEG_9 = 7'b0010000;

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - BCD code to active-low seven-segment pattern
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] pattern
);

  // Pure lookup; non-BCD codes 10..15 render as a blank digit
  always_comb begin
    case (code)
      4'd0:    pattern = SEG_0;
      4'd1:    pattern = SEG_1;
      4'd2:    pattern = SEG_2;
      4'd3:    pattern = SEG_3;
      4'd4:    pattern = SEG_4;
      4'd5:    pattern = SEG_5;
      4'd6:    pattern = SEG_6;
      4'd7:    pattern = SEG_7;
      4'd8:    pattern = SEG_8;
      4'd9:    pattern = SEG_9;
      default: pattern = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_mux.sv
// rtl/seg7_scan_mux.sv - multi-digit seven-segment scan driver; SEG7_LZB_EN enables leading-zero blanking
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   digits_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] PRE_LAST  = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] BLANK_LIM = PW'(BLANK_CYC);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

  logic [PW-1:0]       pre;
  logic [IW-1:0]       idx;
  logic [4*DIGITS-1:0] shadow_digits;
  logic [DIGITS-1:0]   shadow_dp;
  logic [DIGITS-1:0]   lz_mask;
  logic [DIGITS-1:0]   an_next;
  logic [3:0]          sel_code;
  logic                sel_dp;
  logic                sel_lz;
  logic [6:0]          dec_pattern;
  logic                in_blank;

  // Shadow register: holds the displayed value between loads
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_digits <= '0;
      shadow_dp     <= '0;
    end else if (load) begin
      shadow_digits <= digits_in;
      shadow_dp     <= dp_in;
    end
  end

  // Prescaler and digit index; idx steps on the last cycle of each slot
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre <= '0;
      idx <= '0;
    end else if (pre == PRE_LAST) begin
      pre <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      pre <= pre + 1'b1;
    end
  end

`ifdef SEG7_LZB_EN
  // Digit k>0 blanks when it and every higher digit are zero
  always_comb begin
    logic zero_run;
    lz_mask  = '0;
    zero_run = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      zero_run   = zero_run && (shadow_digits[4*k +: 4] == 4'd0);
      lz_mask[k] = zero_run;
    end
  end
`else
  // Every digit is always decoded
  always_comb lz_mask = '0;
`endif

  // Pick the active digit's code, decimal point and blanking flag
  always_comb begin
    sel_code = 4'd0;
    sel_dp   = 1'b0;
    sel_lz   = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx == IW'(k)) begin
        sel_code = shadow_digits[4*k +: 4];
        sel_dp   = shadow_dp[k];
        sel_lz   = lz_mask[k];
      end
    end
    an_next  = ~(DIGITS'(1) << idx);
    in_blank = (pre < BLANK_LIM);
  end

  seg7_decode u_decode (
    .code    (sel_code),
    .pattern (dec_pattern)
  );

  // Registered pin drivers; anti-ghost window turns everything off
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg <= SEG_BLANK;
      dp  <= 1'b1;
      an  <= '1;
    end else if (in_blank) begin
      seg <= SEG_BLANK;
      dp  <= 1'b1;
      an  <= '1;
    end else begin
      seg <= sel_lz ? SEG_BLANK : dec_pattern;
      dp  <= ~sel_dp;
      an  <= an_next;
    end
  end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// tb/tb_seg7_scan_mux.sv - directed self-checking bench for seg7_scan_mux (DIGITS=4, SCAN_DIV=4, BLANK_CYC=1)
module tb_seg7_scan_mux;

  logic        clk;
  logic        reset;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic        load;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;

  int checks;
  int errors;

  seg7_scan_mux #(
    .DIGITS    (4),
    .SCAN_DIV  (4),
    .BLANK_CYC (1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .digits_in (digits_in),
    .dp_in     (dp_in),
    .load      (load),
    .seg       (seg),
    .dp        (dp),
    .an        (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset, released at a falling edge; the next rising edge is edge 1
  task automatic do_reset();
    load      = 1'b0;
    digits_in = 16'h0;
    dp_in     = 4'h0;
    reset     = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL rst_seg_t0 got %h want 7f", seg); end
    checks++; if (dp !== 1'b1) begin errors++; $display("FAIL rst_dp_t0 got %b want 1", dp); end
    checks++; if (an !== 4'b1111) begin errors++; $display("FAIL rst_an_t0 got %b want 1111", an); end
    tick();
    checks++; if (an !== 4'b1111) begin errors++; $display("FAIL rst_an_held got %b want 1111", an); end
    @(negedge clk);
    reset = 1'b0;
    tick();
    checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL rst_seg_blank got %h want 7f", seg); end
    checks++; if (dp !== 1'b1) begin errors++; $display("FAIL rst_dp_blank got %b want 1", dp); end
    checks++; if (an !== 4'b1111) begin errors++; $display("FAIL rst_an_blank got %b want 1111", an); end
    tick();
    checks++; if (an !== 4'b1110) begin errors++; $display("FAIL rst_an_first got %b want 1110", an); end
    checks++; if (seg !== 7'h40) begin errors++; $display("FAIL rst_seg_first got %h want 40", seg); end
  endtask

  task automatic test_scan_order();
    logic [3:0] an_tab [16];
    logic [6:0] seg_tab [16];
    an_tab  = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD,
                4'hF, 4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7};
    seg_tab = '{7'h7F, 7'h19, 7'h19, 7'h19, 7'h7F, 7'h30, 7'h30, 7'h30,
                7'h7F, 7'h24, 7'h24, 7'h24, 7'h7F, 7'h79, 7'h79, 7'h79};
    do_reset();
    digits_in = 16'h1234;
    load      = 1'b1;
    for (int e = 1; e <= 32; e++) begin
      tick();
      load = 1'b0;
      checks++; if (an !== an_tab[(e-1)%16]) begin errors++; $display("FAIL scan_an edge %0d got %b want %b", e, an, an_tab[(e-1)%16]); end
      checks++; if (seg !== seg_tab[(e-1)%16]) begin errors++; $display("FAIL scan_seg edge %0d got %h want %h", e, seg, seg_tab[(e-1)%16]); end
    end
  endtask

  task automatic test_invalid_dp();
    logic [6:0] seg_tab [16];
    logic       dp_tab [16];
    seg_tab = '{7'h7F, 7'h40, 7'h40, 7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h7F,
                7'h7F, 7'h10, 7'h10, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    dp_tab  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    do_reset();
    digits_in = 16'hF9A0;
    dp_in     = 4'b0100;
    load      = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      tick();
      load = 1'b0;
      checks++; if (seg !== seg_tab[e-1]) begin errors++; $display("FAIL inv_seg edge %0d got %h want %h", e, seg, seg_tab[e-1]); end
      checks++; if (dp !== dp_tab[e-1]) begin errors++; $display("FAIL inv_dp edge %0d got %b want %b", e, dp, dp_tab[e-1]); end
    end
  endtask

  task automatic test_load_mid_slot();
    do_reset();
    tick();
    tick();
    checks++; if (seg !== 7'h40) begin errors++; $display("FAIL mid_seg_before got %h want 40", seg); end
    digits_in = 16'h0007;
    load      = 1'b1;
    tick();
    load = 1'b0;
    checks++; if (seg !== 7'h40) begin errors++; $display("FAIL mid_seg_load_edge got %h want 40", seg); end
    checks++; if (an !== 4'b1110) begin errors++; $display("FAIL mid_an_load_edge got %b want 1110", an); end
    tick();
    checks++; if (seg !== 7'h78) begin errors++; $display("FAIL mid_seg_after got %h want 78", seg); end
    checks++; if (an !== 4'b1110) begin errors++; $display("FAIL mid_an_after got %b want 1110", an); end
    tick();
    checks++; if (an !== 4'b1111) begin errors++; $display("FAIL mid_an_slot_end got %b want 1111", an); end
  endtask

  task automatic test_back_to_back();
    logic [6:0] exp_d1;
`ifdef SEG7_LZB_EN
    exp_d1 = 7'h7F;
`else
    exp_d1 = 7'h40;
`endif
    do_reset();
    tick();
    digits_in = 16'h0001;
    load      = 1'b1;
    tick();
    checks++; if (seg !== 7'h40) begin errors++; $display("FAIL b2b_seg_e2 got %h want 40", seg); end
    digits_in = 16'h0002;
    tick();
    checks++; if (seg !== 7'h79) begin errors++; $display("FAIL b2b_seg_e3 got %h want 79", seg); end
    digits_in = 16'h0003;
    tick();
    checks++; if (seg !== 7'h24) begin errors++; $display("FAIL b2b_seg_e4 got %h want 24", seg); end
    load = 1'b0;
    tick();
    checks++; if (an !== 4'b1111) begin errors++; $display("FAIL b2b_an_e5 got %b want 1111", an); end
    tick();
    checks++; if (an !== 4'b1101) begin errors++; $display("FAIL b2b_an_e6 got %b want 1101", an); end
    checks++; if (seg !== exp_d1) begin errors++; $display("FAIL b2b_seg_e6 got %h want %h", seg, exp_d1); end
    repeat (12) tick();
    checks++; if (an !== 4'b1110) begin errors++; $display("FAIL b2b_an_e18 got %b want 1110", an); end
    checks++; if (seg !== 7'h30) begin errors++; $display("FAIL b2b_seg_e18 got %h want 30", seg); end
  endtask

  task automatic test_lzb();
    logic [6:0] z;
    logic [6:0] seg_tab [16];
`ifdef SEG7_LZB_EN
    z = 7'h7F;
`else
    z = 7'h40;
`endif
    seg_tab = '{7'h7F, 7'h40, 7'h40, 7'h40, 7'h7F, 7'h19, 7'h19, 7'h19,
                7'h7F, z, z, z, 7'h7F, z, z, z};
    do_reset();
    digits_in = 16'h0040;
    load      = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      tick();
      load = 1'b0;
      checks++; if (seg !== seg_tab[e-1]) begin errors++; $display("FAIL lzb_seg edge %0d got %h want %h", e, seg, seg_tab[e-1]); end
    end
  endtask

  task automatic test_reset_mid_scan();
    do_reset();
    digits_in = 16'h1234;
    load      = 1'b1;
    tick();
    load = 1'b0;
    repeat (9) tick();
    checks++; if (an !== 4'b1011) begin errors++; $display("FAIL rms_an_before got %b want 1011", an); end
    checks++; if (seg !== 7'h24) begin errors++; $display("FAIL rms_seg_before got %h want 24", seg); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL rms_seg_async got %h want 7f", seg); end
    checks++; if (dp !== 1'b1) begin errors++; $display("FAIL rms_dp_async got %b want 1", dp); end
    checks++; if (an !== 4'b1111) begin errors++; $display("FAIL rms_an_async got %b want 1111", an); end
    @(negedge clk);
    reset = 1'b0;
    tick();
    checks++; if (an !== 4'b1111) begin errors++; $display("FAIL rms_an_blank got %b want 1111", an); end
    tick();
    checks++; if (an !== 4'b1110) begin errors++; $display("FAIL rms_an_first got %b want 1110", an); end
    checks++; if (seg !== 7'h40) begin errors++; $display("FAIL rms_seg_cleared got %h want 40", seg); end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    load      = 1'b0;
    digits_in = 16'h0;
    dp_in     = 4'h0;
    test_reset();
    test_scan_order();
    test_invalid_dp();
    test_load_mid_slot();
    test_back_to_back();
    test_lzb();
    test_reset_mid_scan();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
